rob_multiway: RTL and testbench

Parametrised in-order reorder buffer for the R10K-style pipeline. It sits between dispatch (ID), issue/complete (IC) and retire (IR). Per cycle it accepts up to DISPATCH_W new entries, marks up to CMPL_W entries complete, and retires up to RETIRE_W in-order complete entries. It also supports partial squash on branch mispredict and full flush on exception, which the single-way ROB does not.

---
 rtl/rob_multiway.sv | 129 ++++++++++++
 tb/tb_rob_multiway.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiway.sv
// In-order reorder buffer: multi-lane dispatch, completion and retire, with partial squash and full flush.
// State updates on the next rising edge. Retire outputs and disp_idx are combinational from registered state.
module rob_multiway #(
  parameter  int ROB_SZ     = 32,
  parameter  int TAG_W      = 7,
  parameter  int DISPATCH_W = 2,
  parameter  int CMPL_W     = 2,
  parameter  int RETIRE_W   = 2,
  localparam int IDX_W      = $clog2(ROB_SZ),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DISPATCH_W-1:0]         disp_valid,
  input  logic [DISPATCH_W*TAG_W-1:0]   disp_t,
  input  logic [DISPATCH_W*TAG_W-1:0]   disp_t_old,
  output logic                          disp_accept,
  output logic [DISPATCH_W*IDX_W-1:0]   disp_idx,
  output logic [CNT_W-1:0]              free_slots,
  input  logic [CMPL_W-1:0]             cmpl_valid,
  input  logic [CMPL_W*IDX_W-1:0]       cmpl_idx,
  output logic [RETIRE_W-1:0]           retire_valid,
  output logic [RETIRE_W*TAG_W-1:0]     retire_t,
  output logic [RETIRE_W*TAG_W-1:0]     retire_t_old,
  input  logic                          squash_en,
  input  logic [IDX_W-1:0]              squash_idx,
  input  logic                          flush_all,
  output logic                          empty,
  output logic                          full
);

  logic [IDX_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [TAG_W-1:0]  ent_t     [ROB_SZ];
  logic [TAG_W-1:0]  ent_t_old [ROB_SZ];
  logic [ROB_SZ-1:0] ent_cmpl, cmpl_nxt, alive;

  logic [IDX_W-1:0]  disp_slot [DISPATCH_W];
  logic [IDX_W-1:0]  ret_slot  [RETIRE_W];
  logic [CNT_W-1:0]  n_req, n_acc, n_ret, surv_cnt;
  logic [IDX_W-1:0]  surv_off;
  logic              ret_run;

  for (genvar i = 0; i < DISPATCH_W; i++) begin : g_disp
    assign disp_slot[i]                 = tail + IDX_W'(i);
    assign disp_idx[i*IDX_W +: IDX_W]   = disp_slot[i];
  end

  for (genvar k = 0; k < RETIRE_W; k++) begin : g_ret
    assign ret_slot[k] = head + IDX_W'(k);
  end

  assign free_slots  = CNT_W'(ROB_SZ) - count;
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(ROB_SZ));
  assign surv_off    = squash_idx - head;
  assign surv_cnt    = {1'b0, surv_off} + CNT_W'(1);

  always_comb begin
    n_req = '0;
    for (int i = 0; i < DISPATCH_W; i++) n_req = n_req + CNT_W'(disp_valid[i]);
  end

  // free_slots ignores same-cycle retire, so a full ROB stalls one cycle even while draining.
  assign disp_accept = (n_req <= free_slots) && !squash_en && !flush_all;
  assign n_acc       = disp_accept ? n_req : '0;

  // Retire is a prefix of complete entries starting at head.
  always_comb begin
    ret_run      = !flush_all;
    retire_valid = '0;
    retire_t     = '0;
    retire_t_old = '0;
    n_ret        = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_run = ret_run && (CNT_W'(k) < count) && ent_cmpl[ret_slot[k]];
      retire_valid[k]                 = ret_run;
      retire_t[k*TAG_W +: TAG_W]      = ent_t[ret_slot[k]];
      retire_t_old[k*TAG_W +: TAG_W]  = ent_t_old[ret_slot[k]];
      n_ret = n_ret + CNT_W'(ret_run);
    end
  end

  // Slots at or before squash_idx (relative to head) survive a squash.
  always_comb begin
    alive = '0;
    for (int i = 0; i < ROB_SZ; i++)
      alive[i] = (IDX_W'(IDX_W'(i) - head) <= surv_off);
  end

  always_comb begin
    cmpl_nxt = ent_cmpl;
    for (int k = 0; k < RETIRE_W; k++)
      if (retire_valid[k]) cmpl_nxt[ret_slot[k]] = 1'b0;
    for (int i = 0; i < DISPATCH_W; i++)
      if (disp_accept && disp_valid[i]) cmpl_nxt[disp_slot[i]] = 1'b0;
    for (int c = 0; c < CMPL_W; c++)
      if (cmpl_valid[c]) cmpl_nxt[cmpl_idx[c*IDX_W +: IDX_W]] = 1'b1;
    if (squash_en) cmpl_nxt = cmpl_nxt & alive;
  end

  always_ff @(posedge clock) begin
    if (reset || flush_all) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_cmpl <= '0;
    end else begin
      head     <= head + IDX_W'(n_ret);
      ent_cmpl <= cmpl_nxt;
      if (squash_en) begin
        tail  <= squash_idx + IDX_W'(1);
        count <= surv_cnt - n_ret;
      end else begin
        tail  <= tail + IDX_W'(n_acc);
        count <= count + n_acc - n_ret;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DISPATCH_W; i++)
      if (disp_accept && disp_valid[i]) begin
        ent_t[disp_slot[i]]     <= disp_t[i*TAG_W +: TAG_W];
        ent_t_old[disp_slot[i]] <= disp_t_old[i*TAG_W +: TAG_W];
      end
  end

endmodule

// File: tb/tb_rob_multiway.sv
// Directed bench for rob_multiway: fill/full stall, out-of-order completion, wrap, squash, flush and reset.
module tb_rob_multiway;
  localparam int SZ = 32;
  localparam int TW = 7;
  localparam int IW = 5;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    disp_valid;
  logic [2*TW-1:0] disp_t, disp_t_old;
  logic          disp_accept;
  logic [2*IW-1:0] disp_idx;
  logic [CW-1:0] free_slots;
  logic [1:0]    cmpl_valid;
  logic [2*IW-1:0] cmpl_idx;
  logic [1:0]    retire_valid;
  logic [2*TW-1:0] retire_t, retire_t_old;
  logic          squash_en;
  logic [IW-1:0] squash_idx;
  logic          flush_all;
  logic          empty, full;

  int checks = 0;
  int errors = 0;

  rob_multiway dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_t(disp_t), .disp_t_old(disp_t_old),
    .disp_accept(disp_accept), .disp_idx(disp_idx), .free_slots(free_slots),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .retire_valid(retire_valid), .retire_t(retire_t), .retire_t_old(retire_t_old),
    .squash_en(squash_en), .squash_idx(squash_idx), .flush_all(flush_all),
    .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0; disp_t = '0; disp_t_old = '0;
    cmpl_valid = '0; cmpl_idx = '0;
    squash_en = 1'b0; squash_idx = '0; flush_all = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic disp2(input int t0, input int t1, input logic [1:0] v);
    disp_valid = v;
    disp_t     = {7'(t1), 7'(t0)};
    disp_t_old = {7'(t1) ^ 7'h40, 7'(t0) ^ 7'h40};
  endtask

  task automatic cmpl2(input int s0, input int s1, input logic [1:0] v);
    cmpl_valid = v;
    cmpl_idx   = {5'(s1), 5'(s0)};
  endtask

  // 16 cycles of two dispatches from an empty ROB, tags base, base+1, ...
  task automatic fill(input int base);
    for (int c = 0; c < SZ/2; c++) begin
      idle();
      disp2(base + 2*c, base + 2*c + 1, 2'b11);
      #1;
      chk("fill_acc", 32'(disp_accept), 1);
      chk("fill_idx", 32'(disp_idx[IW-1:0]), 2*c);
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nd, nr;
    logic [IW-1:0] p0, p1;
    bit pv;

    // Reset values
    do_reset();
    #1;
    chk("rst_rv", 32'(retire_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_free", 32'(free_slots), 32);
    chk("rst_acc", 32'(disp_accept), 1);

    // Fill to full, then stall
    fill(8);
    disp2(99, 0, 2'b01);
    #1;
    chk("full_flag", 32'(full), 1);
    chk("full_free", 32'(free_slots), 0);
    chk("full_acc", 32'(disp_accept), 0);
    tick();
    idle(); cmpl2(0, 0, 2'b01); #1; tick();
    idle(); disp2(99, 0, 2'b01); #1;
    chk("ret1_rv", 32'(retire_valid), 1);
    chk("ret1_t", 32'(retire_t[TW-1:0]), 8);
    chk("ret1_told", 32'(retire_t_old[TW-1:0]), 72);
    chk("full_ret_acc", 32'(disp_accept), 0);
    tick();
    idle(); #1;
    chk("ret1_free", 32'(free_slots), 1);
    chk("ret1_rv_after", 32'(retire_valid), 0);

    // Out-of-order completion: head=1, complete 2 then 3, then 1
    cmpl2(2, 0, 2'b01); #1; tick();
    idle(); cmpl2(3, 0, 2'b01); #1;
    chk("ooo_rv0", 32'(retire_valid), 0);
    tick();
    idle(); cmpl2(1, 0, 2'b01); #1;
    chk("ooo_rv1", 32'(retire_valid), 0);
    tick();
    idle(); #1;
    chk("ooo_rv2", 32'(retire_valid), 3);
    chk("ooo_t0", 32'(retire_t[TW-1:0]), 9);
    chk("ooo_t1", 32'(retire_t[2*TW-1:TW]), 10);
    tick();
    #1;
    chk("ooo_rv3", 32'(retire_valid), 1);
    chk("ooo_t3", 32'(retire_t[TW-1:0]), 11);
    tick();
    #1;
    chk("ooo_rv4", 32'(retire_valid), 0);
    chk("ooo_free", 32'(free_slots), 4);

    // Wrap: stream 38 entries, complete each one cycle after dispatch
    do_reset();
    nd = 0; nr = 0; pv = 0; p0 = '0; p1 = '0;
    for (int cyc = 0; cyc < 100 && nr < 38; cyc++) begin
      idle();
      if (pv) cmpl2(int'(p0), int'(p1), 2'b11);
      pv = 0;
      if (nd < 38) disp2(20 + nd, 21 + nd, 2'b11);
      #1;
      if (nd < 38) begin
        chk("wrap_acc", 32'(disp_accept), 1);
        chk("wrap_idx0", 32'(disp_idx[IW-1:0]), nd % SZ);
        chk("wrap_idx1", 32'(disp_idx[2*IW-1:IW]), (nd + 1) % SZ);
        p0 = disp_idx[IW-1:0]; p1 = disp_idx[2*IW-1:IW]; pv = 1;
        nd += 2;
      end
      for (int k = 0; k < 2; k++)
        if (retire_valid[k]) begin
          chk("wrap_rt", 32'(retire_t[k*TW +: TW]), (20 + nr) % 128);
          nr++;
        end
      tick();
    end
    idle(); #1;
    chk("wrap_nret", 32'(nr), 38);
    chk("wrap_empty", 32'(empty), 1);

    // Squash: head=3 with 10 entries (slots 3..12), tags 40+slot
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      disp2(40 + 2*c, 41 + 2*c, (c < 6) ? 2'b11 : 2'b01);
      #1; tick();
    end
    idle(); cmpl2(0, 1, 2'b11); #1; tick();
    idle(); cmpl2(2, 0, 2'b01); #1; tick();
    idle(); #1; tick();
    #1;
    chk("sq_pre_free", 32'(free_slots), 22);
    chk("sq_pre_tail", 32'(disp_idx[IW-1:0]), 13);
    squash_en = 1'b1; squash_idx = 5'd5;
    cmpl2(8, 0, 2'b01);
    disp2(100, 0, 2'b01);
    #1;
    chk("sq_acc", 32'(disp_accept), 0);
    tick();
    idle(); #1;
    chk("sq_free", 32'(free_slots), 29);
    chk("sq_tail", 32'(disp_idx[IW-1:0]), 6);
    chk("sq_rv", 32'(retire_valid), 0);
    disp2(100, 0, 2'b01); #1;
    chk("sq_redisp_acc", 32'(disp_accept), 1);
    tick();
    idle(); cmpl2(3, 4, 2'b11); #1; tick();
    idle(); cmpl2(5, 0, 2'b01); #1;
    chk("sq_ret_rv", 32'(retire_valid), 3);
    chk("sq_ret_t0", 32'(retire_t[TW-1:0]), 43);
    chk("sq_ret_t1", 32'(retire_t[2*TW-1:TW]), 44);
    tick();
    idle(); #1;
    chk("sq_ret5_rv", 32'(retire_valid), 1);
    chk("sq_ret5_t", 32'(retire_t[TW-1:0]), 45);
    tick();
    idle(); disp2(110, 111, 2'b11); #1;
    chk("sq_slot6_incomplete", 32'(retire_valid), 0);
    chk("sq_disp_idx7", 32'(disp_idx[IW-1:0]), 7);
    tick();
    idle(); cmpl2(6, 7, 2'b11); #1; tick();
    idle(); #1;
    chk("sq_new_rv", 32'(retire_valid), 3);
    chk("sq_new_t0", 32'(retire_t[TW-1:0]), 100);
    chk("sq_new_t1", 32'(retire_t[2*TW-1:TW]), 110);
    tick();
    #1;
    chk("sq_slot8_incomplete", 32'(retire_valid), 0);

    // flush_all with squash, completions and dispatch on a full ROB
    do_reset();
    fill(0);
    cmpl2(0, 1, 2'b11); #1; tick();
    idle();
    flush_all = 1'b1; squash_en = 1'b1; squash_idx = 5'd10;
    cmpl2(2, 3, 2'b11); disp2(1, 2, 2'b11);
    #1;
    chk("fl_rv_forced", 32'(retire_valid), 0);
    chk("fl_acc", 32'(disp_accept), 0);
    tick();
    idle(); #1;
    chk("fl_empty", 32'(empty), 1);
    chk("fl_full", 32'(full), 0);
    chk("fl_free", 32'(free_slots), 32);
    chk("fl_rv", 32'(retire_valid), 0);
    chk("fl_tail", 32'(disp_idx[IW-1:0]), 0);

    // Reset while full and retiring
    do_reset();
    fill(60);
    cmpl2(0, 1, 2'b11); #1; tick();
    idle(); cmpl2(2, 3, 2'b11); disp2(1, 2, 2'b11);
    reset = 1'b1;
    #1; tick();
    reset = 1'b0;
    idle(); #1;
    chk("rr_rv", 32'(retire_valid), 0);
    chk("rr_empty", 32'(empty), 1);
    chk("rr_full", 32'(full), 0);
    chk("rr_free", 32'(free_slots), 32);
    chk("rr_acc", 32'(disp_accept), 1);
    disp2(5, 0, 2'b01); #1; tick();
    idle(); #1;
    chk("rr_no_stale", 32'(retire_valid), 0);
    cmpl2(0, 0, 2'b01); #1; tick();
    idle(); #1;
    chk("rr_new_rv", 32'(retire_valid), 1);
    chk("rr_new_t", 32'(retire_t[TW-1:0]), 5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
